// File: rtl/ro_puf_pkg.sv
// Shared types and default timing constants for the RO-PUF measurement controller.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StSettle,
    StCapture,
    StDone
  } ro_puf_state_e;

  localparam int unsigned DefCntW          = 16;
  localparam int unsigned DefClearCycles   = 4;
  localparam int unsigned DefWindowCycles  = 1000;
  localparam int unsigned DefSettleCycles  = 4;

endpackage

// File: rtl/ro_phase_timer.sv
// Loadable down-counter shared by the CLEAR, RUN and SETTLE phases; holds at zero.
module ro_phase_timer #(
  parameter int unsigned TMR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ro_puf_measure_ctrl.sv
// Walks every RO pair through clear/run/settle/capture and assembles the PUF response word.
module ro_puf_measure_ctrl
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_PAIRS     = 8,
  parameter int unsigned PAIR_W        = 3,
  parameter int unsigned CNT_W         = DefCntW,
  parameter int unsigned TMR_W         = 16,
  parameter int unsigned CLEAR_CYCLES  = DefClearCycles,
  parameter int unsigned WINDOW_CYCLES = DefWindowCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     ro0_count,
  input  logic [CNT_W-1:0]     ro1_count,
  output logic [PAIR_W-1:0]    pair_sel,
  output logic                 ro_enable,
  output logic                 ro_cnt_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_PAIRS-1:0] response,
  output logic [PAIR_W:0]      tie_count
);

  ro_puf_state_e        state_q, state_d;
  logic [PAIR_W-1:0]    pair_sel_q, pair_sel_d;
  logic [NUM_PAIRS-1:0] response_q, response_d;
  logic [PAIR_W:0]      tie_count_q, tie_count_d;
  logic                 ro_enable_q, ro_enable_d;
  logic                 ro_cnt_reset_n_q, ro_cnt_reset_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 timer_load;
  logic [TMR_W-1:0]     timer_load_val;
  logic                 timer_zero;

  ro_phase_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d        = state_q;
    pair_sel_d     = pair_sel_q;
    response_d     = response_q;
    tie_count_d    = tie_count_q;
    timer_load     = 1'b0;
    timer_load_val = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d        = StClear;
          pair_sel_d     = '0;
          response_d     = '0;
          tie_count_d    = '0;
          timer_load     = 1'b1;
          timer_load_val = TMR_W'(CLEAR_CYCLES - 1);
        end
      end
      StClear: begin
        if (timer_zero) begin
          state_d        = StRun;
          timer_load     = 1'b1;
          timer_load_val = TMR_W'(WINDOW_CYCLES - 1);
        end
      end
      StRun: begin
        if (timer_zero) begin
          state_d        = StSettle;
          timer_load     = 1'b1;
          timer_load_val = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (timer_zero) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        response_d[pair_sel_q] = (ro0_count > ro1_count);
        if (ro0_count == ro1_count) begin
          tie_count_d = tie_count_q + (PAIR_W + 1)'(1);
        end
        if (pair_sel_q == PAIR_W'(NUM_PAIRS - 1)) begin
          state_d = StDone;
        end else begin
          state_d        = StClear;
          pair_sel_d     = pair_sel_q + PAIR_W'(1);
          timer_load     = 1'b1;
          timer_load_val = TMR_W'(CLEAR_CYCLES - 1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort beats start and discards any capture happening this cycle.
    if (abort) begin
      state_d     = StIdle;
      pair_sel_d  = '0;
      response_d  = response_q;
      tie_count_d = tie_count_q;
    end

    // Outputs are decoded from the next state so they register in step with it.
    ro_enable_d      = (state_d == StRun);
    ro_cnt_reset_n_d = (state_d == StRun) || (state_d == StSettle) || (state_d == StCapture);
    busy_d           = (state_d != StIdle);
    done_d           = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      pair_sel_q       <= '0;
      response_q       <= '0;
      tie_count_q      <= '0;
      ro_enable_q      <= 1'b0;
      ro_cnt_reset_n_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pair_sel_q       <= pair_sel_d;
      response_q       <= response_d;
      tie_count_q      <= tie_count_d;
      ro_enable_q      <= ro_enable_d;
      ro_cnt_reset_n_q <= ro_cnt_reset_n_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign pair_sel       = pair_sel_q;
  assign ro_enable      = ro_enable_q;
  assign ro_cnt_reset_n = ro_cnt_reset_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign response       = response_q;
  assign tie_count      = tie_count_q;

endmodule

// File: tb/tb_ro_puf_measure_ctrl.sv
// Scoreboard bench: expected response/tie pushed at each start, popped at each done pulse.
module tb_ro_puf_measure_ctrl;

  localparam int unsigned NP      = 4;
  localparam int unsigned PW      = 2;
  localparam int unsigned CW      = 16;
  localparam int          RUN_LAT = 53;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] ro0_count;
  logic [CW-1:0] ro1_count;
  logic [PW-1:0] pair_sel;
  logic          ro_enable;
  logic          ro_cnt_reset_n;
  logic          busy;
  logic          done;
  logic [NP-1:0] response;
  logic [PW:0]   tie_count;

  logic [CW-1:0] c0_tab [NP];
  logic [CW-1:0] c1_tab [NP];

  logic [NP-1:0] exp_resp_q [$];
  logic [PW:0]   exp_tie_q  [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ro0_count = c0_tab[pair_sel];
  assign ro1_count = c1_tab[pair_sel];

  ro_puf_measure_ctrl #(
    .NUM_PAIRS     (NP),
    .PAIR_W        (PW),
    .CNT_W         (CW),
    .TMR_W         (16),
    .CLEAR_CYCLES  (2),
    .WINDOW_CYCLES (8),
    .SETTLE_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .ro0_count      (ro0_count),
    .ro1_count      (ro1_count),
    .pair_sel       (pair_sel),
    .ro_enable      (ro_enable),
    .ro_cnt_reset_n (ro_cnt_reset_n),
    .busy           (busy),
    .done           (done),
    .response       (response),
    .tie_count      (tie_count)
  );

  task automatic load_tables(input bit tie_pair1);
    c0_tab[0] = 16'd120; c1_tab[0] = 16'd100;
    c0_tab[1] = 16'd90;  c1_tab[1] = 16'd95;
    c0_tab[2] = 16'd200; c1_tab[2] = 16'd199;
    c0_tab[3] = 16'd50;  c1_tab[3] = 16'd60;
    if (tie_pair1) begin
      c0_tab[1] = 16'd77; c1_tab[1] = 16'd77;
    end
  endtask

  task automatic push_expected();
    logic [NP-1:0] r;
    logic [PW:0]   t;
    r = '0;
    t = '0;
    for (int i = 0; i < int'(NP); i++) begin
      r[i] = (c0_tab[i] > c1_tab[i]);
      if (c0_tab[i] == c1_tab[i]) t = t + 1'b1;
    end
    exp_resp_q.push_back(r);
    exp_tie_q.push_back(t);
  endtask

  // Leaves the bench at the negedge that is cycle 1 of the run.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int restart_at, output int lat,
                           output bit seen, output bit busy_drop, output bit overlap);
    lat = 0; seen = 1'b0; busy_drop = 1'b0; overlap = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == restart_at);
      if (!ro_cnt_reset_n && ro_enable) overlap = 1'b1;
      if (!busy) busy_drop = 1'b1;
      if (done) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string name);
    logic [NP-1:0] er;
    logic [PW:0]   et;
    checks++;
    if (exp_resp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: done with empty scoreboard", name);
    end else begin
      er = exp_resp_q.pop_front();
      et = exp_tie_q.pop_front();
      if (response !== er) begin
        errors++;
        $display("FAIL %s response: got %b expected %b", name, response, er);
      end
      checks++;
      if (tie_count !== et) begin
        errors++;
        $display("FAIL %s tie_count: got %0d expected %0d", name, tie_count, et);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (pair_sel !== '0 || ro_enable !== 1'b0 || ro_cnt_reset_n !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || response !== '0 || tie_count !== '0) begin
      errors++;
      $display("FAIL %s: got sel=%0d en=%b rstn=%b busy=%b done=%b resp=%b tie=%0d expected all 0",
               name, pair_sel, ro_enable, ro_cnt_reset_n, busy, done, response, tie_count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    load_tables(1'b0);
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_basic();
    int lat; bit seen, bdrop, ovl;
    load_tables(1'b0);
    push_expected();
    pulse_start();
    wait_done(80, 0, lat, seen, bdrop, ovl);
    checks++;
    if (!seen || lat != RUN_LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d (seen=%b) expected %0d", lat, seen, RUN_LAT);
    end
    checks++;
    if (ovl) begin
      errors++;
      $display("FAIL basic_enable_in_reset: got overlap=1 expected 0");
    end
    if (seen) check_result("basic");
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_phases();
    int lat; bit seen, bdrop, ovl;
    bit exp_rstn, exp_en;
    logic [PW-1:0] exp_sel;
    load_tables(1'b0);
    push_expected();
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      exp_rstn = (c >= 3 && c <= 13);
      exp_en   = (c >= 3 && c <= 10);
      exp_sel  = (c == 14) ? PW'(1) : PW'(0);
      checks++;
      if (ro_cnt_reset_n !== exp_rstn || ro_enable !== exp_en || pair_sel !== exp_sel) begin
        errors++;
        $display("FAIL phase_c%0d: got rstn=%b en=%b sel=%0d expected rstn=%b en=%b sel=%0d",
                 c, ro_cnt_reset_n, ro_enable, pair_sel, exp_rstn, exp_en, exp_sel);
      end
    end
    wait_done(60, 0, lat, seen, bdrop, ovl);
    checks++;
    if (!seen || lat != RUN_LAT - 13) begin
      errors++;
      $display("FAIL phases_done: got %0d (seen=%b) expected %0d", lat, seen, RUN_LAT - 13);
    end
    if (seen) check_result("phases");
  endtask

  task automatic test_tie();
    int lat; bit seen, bdrop, ovl;
    load_tables(1'b1);
    push_expected();
    pulse_start();
    wait_done(80, 0, lat, seen, bdrop, ovl);
    checks++;
    if (!seen || lat != RUN_LAT) begin
      errors++;
      $display("FAIL tie_latency: got %0d (seen=%b) expected %0d", lat, seen, RUN_LAT);
    end
    if (seen) check_result("tie");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit seen, bdrop, ovl;
    load_tables(1'b0);
    push_expected();
    pulse_start();
    wait_done(80, 20, lat, seen, bdrop, ovl);
    checks++;
    if (!seen || lat != RUN_LAT) begin
      errors++;
      $display("FAIL restart_latency: got %0d (seen=%b) expected %0d", lat, seen, RUN_LAT);
    end
    checks++;
    if (bdrop) begin
      errors++;
      $display("FAIL restart_busy: got busy drop=1 expected 0");
    end
    if (seen) check_result("restart");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    load_tables(1'b0);
    pulse_start();
    repeat (29) @(negedge clk);
    checks++;
    if (pair_sel !== PW'(2) || ro_enable !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: got sel=%0d en=%b expected sel=2 en=1", pair_sel, ro_enable);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ro_enable !== 1'b0 || ro_cnt_reset_n !== 1'b0 || pair_sel !== '0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b en=%b rstn=%b sel=%0d expected 0 0 0 0",
               busy, ro_enable, ro_cnt_reset_n, pair_sel);
    end
    checks++;
    if (response[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL abort_partial: got %b expected 01", response[1:0]);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: got done=1 expected 0");
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit seen, bdrop, ovl;
    load_tables(1'b1);
    pulse_start();
    repeat (31) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_reset_mid_run");
    @(negedge clk);
    reset_n = 1'b1;
    load_tables(1'b0);
    push_expected();
    pulse_start();
    wait_done(80, 0, lat, seen, bdrop, ovl);
    checks++;
    if (!seen || lat != RUN_LAT) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d (seen=%b) expected %0d", lat, seen, RUN_LAT);
    end
    if (seen) check_result("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phases();
    test_tie();
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    checks++;
    if (exp_resp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_resp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_measure_ctrl.md
Name: ro_puf_measure_ctrl

Overview:
- Sequences one or more RO-pair counter blocks to produce a weak-PUF response word.
- Walks NUM_PAIRS challenge indices (pair_sel drives an external mux over RO-pair counter blocks). For each index it clears the counters, enables the ROs for a fixed window of system clocks, stops them, lets counts settle, then captures one response bit.
- Sits between the top-level readout/UART logic and the RO-pair counter array.

Parameters:
- NUM_PAIRS, 8, number of RO pairs measured per run (≥2).
- PAIR_W, 3, width of pair_sel; equals clog2(NUM_PAIRS).
- CNT_W, 16, width of each RO count input.
- TMR_W, 16, width of the internal phase timer.
- CLEAR_CYCLES, 4, clk cycles counter reset is held low (≥1).
- WINDOW_CYCLES, 1000, clk cycles ROs are enabled (≥1). Must be chosen so that RO counts stay below 2^CNT_W.
- SETTLE_CYCLES, 4, clk cycles between RO disable and count capture (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- ro0_count  in  CNT_W  RO0 counter value of the selected pair.
- ro1_count  in  CNT_W  RO1 counter value of the selected pair.
- pair_sel  out  PAIR_W  index of the pair currently being measured.
- ro_enable  out  1  RO enable to the selected pair.
- ro_cnt_reset_n  out  1  active-low reset to the selected pair's counters.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all pairs have been captured.
- response  out  NUM_PAIRS  response word; bit i belongs to pair i.
- tie_count  out  PAIR_W+1  number of pairs whose two counts were equal.

Behaviour:
- Reset values: pair_sel=0, ro_enable=0, ro_cnt_reset_n=0 (counters held in reset), busy=0, done=0, response=0, tie_count=0, state=IDLE, timer=0.
- All outputs are registered. ro_enable is driven low whenever the state is not RUN.
- IDLE:
  - ro_cnt_reset_n=0.
  - start=1 → next cycle go to CLEAR; set pair_sel=0, response=0, tie_count=0; load timer=CLEAR_CYCLES-1.
- CLEAR:
  - ro_cnt_reset_n=0, ro_enable=0.
  - Timer decrements each cycle. At 0 → go to RUN and load timer=WINDOW_CYCLES-1.
- RUN:
  - ro_cnt_reset_n=1, ro_enable=1, for exactly WINDOW_CYCLES cycles.
  - At timer 0 → go to SETTLE and load timer=SETTLE_CYCLES-1.
- SETTLE:
  - ro_cnt_reset_n=1, ro_enable=0 (ROs stop, counts freeze).
  - At timer 0 → go to CAPTURE.
- CAPTURE (1 cycle):
  - response[pair_sel] <= (ro0_count > ro1_count), unsigned compare.
  - If ro0_count == ro1_count: bit is 0 and tie_count increments.
  - If pair_sel == NUM_PAIRS-1 → go to DONE. Otherwise pair_sel increments, go to CLEAR, and load the CLEAR timer.
- DONE:
  - done=1 for this single cycle, then go to IDLE.
  - response and tie_count are held until the next accepted start.
- Cycles per pair = CLEAR_CYCLES + WINDOW_CYCLES + SETTLE_CYCLES + 1.
- Run latency from the start cycle to the done pulse = NUM_PAIRS × per-pair cycles + 1.
- start while busy is ignored, with no restart.
- start and abort in the same cycle: abort wins.
- abort (any state):
  - Next cycle state=IDLE, ro_enable=0, ro_cnt_reset_n=0, pair_sel=0.
  - No done pulse; response and tie_count keep their partial values.
- Asynchronous reset mid-run: all outputs return immediately to their reset values.
- Counts are captured only after SETTLE, once ROs are stopped, so they are static at capture and no CDC synchronizer is needed. CNT_W wrap-around is not detected; WINDOW_CYCLES sizing is the user's responsibility.

Decomposition:
- Package ro_puf_pkg holds:
  - state enum: IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE;
  - default constants for CLEAR_CYCLES, WINDOW_CYCLES, SETTLE_CYCLES and CNT_W.
- One sub-module, ro_phase_timer: TMR_W loadable down-counter with load, load_val and zero outputs. It is used for all three timed phases.

Test Plan (NUM_PAIRS=4, CLEAR=2, WINDOW=8, SETTLE=2; model drives counts per pair_sel):
- Counts (ro0,ro1) per pair = (120,100), (90,95), (200,199), (50,60); pulse start → done exactly 4×13+1=53 cycles later; response=4'b0101, tie_count=0.
- Check one pair's phases: ro_cnt_reset_n low for 2 cycles, then ro_enable high for exactly 8 cycles, then 2 settle cycles, then capture; ro_enable never high while ro_cnt_reset_n is low.
- Pair 1 counts (77,77), others as in scenario 1 → response bit1=0, tie_count=1.
- Pulse start again at cycle 20 of a run → ignored; done still arrives at cycle 53 and busy stays high throughout.
- abort during RUN of pair 2 → next cycle busy=0, ro_enable=0, pair_sel=0, no done; response bits 0–1 keep their captured values.
- Deassert reset_n mid-RUN → outputs immediately go to reset values; a fresh start then completes a full run normally.
